conv_array_seq: RTL and testbench
=================================

CONV_ARRAY_SEQ -- requirements
Module: conv_array_seq

Interface
REQ-001 SHALL have parameter ROWS, default 4: PE rows, one kernel word per row.
REQ-002 SHALL have parameter COLS, default 4: PE columns, one neuron word per column; ROWS and COLS are independent.
REQ-003 SHALL have parameter W, default 16: signed data and accumulator width.
REQ-004 SHALL have parameter FRAC, default 0: arithmetic right shift applied to each product.
REQ-005 SHALL have parameter L, default 8: width of the step-count field.
REQ-006 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port RESETn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: begin a tile; sampled only in IDLE.
REQ-009 SHALL have port cfg_len, input, L: MAC steps per tile; captured when start is accepted.
REQ-010 SHALL have port partialSumIn, input, W*ROWS: per-row bias; row i occupies bits W*(i+1)-1 down to W*i.
REQ-011 SHALL have port kBuffIn, input, W*ROWS: per-row kernel operand.
REQ-012 SHALL have port nBuffIn, input, W*COLS: per-column neuron operand.
REQ-013 SHALL have port in_valid, input, 1: operands valid.
REQ-014 SHALL have port in_ready, output, 1: array accepts operands.
REQ-015 SHALL have port out_valid, output, 1: a result row is presented.
REQ-016 SHALL have port out_ready, input, 1: the consumer accepts the row.
REQ-017 SHALL have port out_row, output, clog2(ROWS) (minimum 1): index of the presented row.
REQ-018 SHALL have port partialSumOut, output, W*COLS: accumulators of row out_row; column j occupies bits W*(j+1)-1 down to W*j.
REQ-019 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-020 SHALL have port done, output, 1: one-cycle pulse after the last row is drained.

Function
REQ-021 SHALL implement the FSM states IDLE, ACCUM and DRAIN.
REQ-022 SHALL, in IDLE with start=1 and cfg_len!=0, load acc[i][j] with bias[i] for every j, latch cfg_len, clear the step counter, and enter ACCUM.
REQ-023 SHALL, in IDLE with start=1 and cfg_len=0, load the bias values and enter DRAIN directly, skipping ACCUM.
REQ-024 SHALL ignore start in ACCUM and DRAIN; the latched length is unaffected.
REQ-025 SHALL assert in_ready only in ACCUM; a beat is transferred only on in_valid and in_ready both high.
REQ-026 SHALL, on each beat, update every accumulator as acc[i][j] = sat_W(acc[i][j] + ((k[i]*n[j]) >>> FRAC)).
REQ-027 SHALL form the product at full 2W-bit signed precision and perform the addition at 2W+1 bits before saturation.
REQ-028 SHALL saturate to the range +(2^(W-1)-1) down to -2^(W-1).
REQ-029 SHALL leave accumulators and the step counter unchanged on cycles with in_valid=0 (bubbles).
REQ-030 SHALL, on the beat with step count equal to len-1, apply that final update and enter DRAIN with out_row=0.
REQ-031 SHALL hold out_valid=1 throughout DRAIN, with partialSumOut equal to accumulator row out_row (registered, no combinational path from inputs).
REQ-032 SHALL, on out_valid and out_ready both high, increment out_row.
REQ-033 SHALL hold out_row and partialSumOut stable while out_ready=0.
REQ-034 SHALL, on the handshake of row ROWS-1, return to IDLE and assert done for exactly the next cycle.
REQ-035 SHALL allow start to be accepted in the cycle in which done is high.
REQ-036 SHALL drive partialSumOut to 0 and out_valid to 0 outside DRAIN.
REQ-037 SHALL make the first result row available one cycle after the final ACCUM beat; total tile latency is len + ROWS cycles with no stalls.

Reset
REQ-038 SHALL, on RESETn=0 at any time including mid-tile, immediately set state=IDLE, all accumulators=0, step counter=0, out_row=0, and in_ready, out_valid, busy, done, partialSumOut all 0.
REQ-039 SHALL abandon any partially accumulated tile on reset and produce no done pulse for it.

Verification
REQ-040 SHALL cover reset: RESETn=0 asynchronously -> all outputs 0 and busy=0 before the next clock edge.
REQ-041 SHALL cover a basic tile: bias=10 on every row, k=2, n=3, cfg_len=3, in_valid continuous, out_ready=1 -> rows 0..3 each output all columns 28 on consecutive cycles, then done pulses once; no stalls means len + ROWS cycles.
REQ-042 SHALL cover bubbles and backpressure: in_valid pattern 1,0,1,0,1 with out_ready low for 3 cycles on row 1 -> results still 28, and row 1 data held constant during the stall.
REQ-043 SHALL cover saturation: k=0x7FFF, n=0x7FFF, bias=0, cfg_len=2 -> output 0x7FFF; with k=0x8000, n=0x7FFF -> output 0x8000.
REQ-044 SHALL cover zero length: start with cfg_len=0 and bias rows 1,2,3,4 -> in_ready never asserted; rows drained as 1,2,3,4.
REQ-045 SHALL cover reset mid-ACCUM after 1 beat: RESETn pulse -> IDLE with no done pulse; a following tile produces the correct 28 results.

Source files
------------

// File: rtl/conv_array_seq.sv
// Output-stationary ROWS x COLS MAC array: bias-load, accumulate len beats of
// kernel x neuron outer products, then drain one accumulator row per handshake.
module conv_array_seq #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W    = 16,
  parameter int FRAC = 0,
  parameter int L    = 8,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  input  logic [L-1:0]        cfg_len,
  input  logic [W*ROWS-1:0]   partialSumIn,
  input  logic [W*ROWS-1:0]   kBuffIn,
  input  logic [W*COLS-1:0]   nBuffIn,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       out_row,
  output logic [W*COLS-1:0]   partialSumOut,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  state_t                state_q, state_d;
  logic signed [W-1:0]   acc_q [ROWS][COLS];
  logic signed [W-1:0]   acc_d [ROWS][COLS];
  logic [L-1:0]          len_q, len_d;
  logic [L-1:0]          step_q, step_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  done_q, done_d;

  function automatic logic signed [W-1:0] sat(input logic signed [2*W:0] s);
    if (s > MAXV)      sat = MAXV[W-1:0];
    else if (s < MINV) sat = MINV[W-1:0];
    else               sat = s[W-1:0];
  endfunction

  // Full-precision product, scaled, then a 2W+1-bit add so the sum cannot wrap.
  function automatic logic signed [W-1:0] mac(input logic signed [W-1:0] acc,
                                              input logic signed [W-1:0] k,
                                              input logic signed [W-1:0] n);
    logic signed [2*W-1:0] ke, ne, p;
    logic signed [2*W:0]   s;
    ke  = {{W{k[W-1]}}, k};
    ne  = {{W{n[W-1]}}, n};
    p   = (ke * ne) >>> FRAC;
    s   = $signed({{(W+1){acc[W-1]}}, acc}) + $signed({p[2*W-1], p});
    mac = sat(s);
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    step_d  = step_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
              acc_d[i][j] = partialSumIn[W*i +: W];
          len_d   = cfg_len;
          step_d  = '0;
          row_d   = '0;
          state_d = (cfg_len == '0) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
              acc_d[i][j] = mac(acc_q[i][j], kBuffIn[W*i +: W], nBuffIn[W*j +: W]);
          step_d = step_q + L'(1);
          if (step_q == len_q - L'(1)) begin
            state_d = S_DRAIN;
            row_d   = '0;
            step_d  = '0;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = S_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      step_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      step_q  <= step_d;
      row_q   <= row_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs decode registered state only; nothing flows through from inputs.
  always_comb begin
    partialSumOut = '0;
    if (state_q == S_DRAIN)
      for (int j = 0; j < COLS; j++)
        partialSumOut[W*j +: W] = acc_q[row_q][j];
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign out_row   = row_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_array_seq.sv
// Directed bench for conv_array_seq (4x4, W=16): basic tile, bubbles and
// backpressure, saturation, zero length and asynchronous reset mid-tile.
module tb_conv_array_seq;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        start;
  logic [7:0]  cfg_len;
  logic [63:0] partialSumIn;
  logic [63:0] kBuffIn;
  logic [63:0] nBuffIn;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_row;
  logic [63:0] partialSumOut;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  conv_array_seq #(.ROWS(4), .COLS(4), .W(16), .FRAC(0), .L(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .cfg_len(cfg_len),
    .partialSumIn(partialSumIn), .kBuffIn(kBuffIn), .nBuffIn(nBuffIn),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .partialSumOut(partialSumOut),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge CLK);
  endtask

  task automatic start_tile(input logic [15:0] bias, input logic [15:0] k,
                            input logic [15:0] n, input logic [7:0] len);
    partialSumIn = {4{bias}};
    kBuffIn      = {4{k}};
    nBuffIn      = {4{n}};
    cfg_len      = len;
    start        = 1'b1;
    nclk();
    start        = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc);
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      nclk();
      cyc++;
    end
    chk(tag, 64'(cyc), 64'(exp_cyc));
  endtask

  // Drains four rows with out_ready high; returns in the done cycle.
  task automatic drain_rows(input string tag, input logic [63:0] exp);
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("%s_vld%0d", tag, r), 64'(out_valid), 64'd1);
      chk($sformatf("%s_row%0d", tag, r), 64'(out_row), 64'(r));
      chk($sformatf("%s_psum%0d", tag, r), partialSumOut, exp);
      chk($sformatf("%s_rdy%0d", tag, r), 64'(in_ready), 64'd0);
      nclk();
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_vld_off"}, 64'(out_valid), 64'd0);
    chk({tag, "_psum_off"}, partialSumOut, 64'd0);
  endtask

  initial begin
    logic [15:0] v;
    RESETn = 1'b1; start = 1'b0; cfg_len = '0; partialSumIn = '0;
    kBuffIn = '0; nBuffIn = '0; in_valid = 1'b0; out_ready = 1'b1;

    // Asynchronous reset, observed before the first clock edge.
    #2 RESETn = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_psum", partialSumOut, 64'd0);
    chk("rst_row", 64'(out_row), 64'd0);
    nclk(); nclk();
    RESETn = 1'b1;
    nclk();

    // Basic tile: 10 + 3*(2*3) = 28.
    in_valid = 1'b1;
    start_tile(16'd10, 16'd2, 16'd3, 8'd3);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    wait_valid("t1_latency", 3);
    in_valid = 1'b0;
    drain_rows("t1", {4{16'd28}});
    nclk();
    chk("t1_done_once", 64'(done), 64'd0);

    // Bubbles 1,0,1,0,1 with start/cfg_len toggled during ACCUM, then a 3-cycle stall on row 1.
    partialSumIn = {4{16'd10}}; kBuffIn = {4{16'd2}}; nBuffIn = {4{16'd3}};
    cfg_len = 8'd3; start = 1'b1;
    nclk();
    cfg_len = 8'd9;
    in_valid = 1'b1; nclk();
    chk("t2_rdy_bubble", 64'(in_ready), 64'd1);
    in_valid = 1'b0; nclk();
    in_valid = 1'b1; nclk();
    chk("t2_still_accum", 64'(out_valid), 64'd0);
    in_valid = 1'b0; nclk();
    in_valid = 1'b1; start = 1'b0; nclk();
    in_valid = 1'b0;
    chk("t2_row0", 64'(out_row), 64'd0);
    chk("t2_psum0", partialSumOut, {4{16'd28}});
    nclk();
    chk("t2_row1", 64'(out_row), 64'd1);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      nclk();
      chk($sformatf("t2_stall_row%0d", s), 64'(out_row), 64'd1);
      chk($sformatf("t2_stall_psum%0d", s), partialSumOut, {4{16'd28}});
      chk($sformatf("t2_stall_vld%0d", s), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    nclk();
    chk("t2_row2", 64'(out_row), 64'd2);
    chk("t2_psum2", partialSumOut, {4{16'd28}});
    nclk();
    chk("t2_row3", 64'(out_row), 64'd3);
    nclk();
    chk("t2_done", 64'(done), 64'd1);
    nclk();
    chk("t2_done_once", 64'(done), 64'd0);

    // Positive saturation, then a new start accepted in the done cycle for negative saturation.
    in_valid = 1'b1;
    start_tile(16'd0, 16'h7FFF, 16'h7FFF, 8'd2);
    wait_valid("t3_latency", 2);
    drain_rows("t3_pos", {4{16'h7FFF}});
    kBuffIn = {4{16'h8000}}; cfg_len = 8'd2; start = 1'b1;
    nclk();
    start = 1'b0;
    chk("t3_start_on_done", 64'(busy), 64'd1);
    wait_valid("t3_neg_latency", 2);
    in_valid = 1'b0;
    drain_rows("t3_neg", {4{16'h8000}});
    nclk();

    // Zero length: straight to DRAIN with the bias rows.
    partialSumIn = {16'd4, 16'd3, 16'd2, 16'd1};
    cfg_len = 8'd0; in_valid = 1'b1; start = 1'b1;
    nclk();
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      v = 16'(r + 1);
      chk($sformatf("t4_rdy%0d", r), 64'(in_ready), 64'd0);
      chk($sformatf("t4_vld%0d", r), 64'(out_valid), 64'd1);
      chk($sformatf("t4_row%0d", r), 64'(out_row), 64'(r));
      chk($sformatf("t4_psum%0d", r), partialSumOut, {v, v, v, v});
      nclk();
    end
    chk("t4_done", 64'(done), 64'd1);
    in_valid = 1'b0;
    nclk();

    // Reset after one ACCUM beat: tile abandoned, no done pulse.
    in_valid = 1'b1;
    start_tile(16'd10, 16'd2, 16'd3, 8'd3);
    nclk();
    in_valid = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_psum", partialSumOut, 64'd0);
    nclk();
    RESETn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      nclk();
      chk($sformatf("t5_no_done%0d", c), 64'(done), 64'd0);
    end
    chk("t5_idle", 64'(busy), 64'd0);
    in_valid = 1'b1;
    start_tile(16'd10, 16'd2, 16'd3, 8'd3);
    wait_valid("t5_latency", 3);
    in_valid = 1'b0;
    drain_rows("t5", {4{16'd28}});
    nclk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
